ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the multicycle CPU. It owns the PC and runs the handshake with instruction memory. It latches each fetched word into the instruction register (IR) and presents the decoded fields (`op`, `funct`, register and immediate fields) to the controller. It then holds that instruction until the controller retires it, and applies the controller's PC-update decision at retire time.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC value loaded by reset; must be word aligned.

Ports:
- `clk`  in  1  system clock; everything is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory returns data this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `instr_valid`  out  1  IR holds an instruction not yet retired.
- `instr_ready`  in  1  controller retires the current instruction this cycle.
- `pc_enab`  in  1  at retire, load `pc_next` instead of `pc+4`.
- `pc_next`  in  32  branch/jump target.
- `op`  out  6  IR[31:26].
- `funct`  out  6  IR[5:0].
- `rs`, `rt`, `rd`  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- `imm`  out  16  IR[15:0].
- `jaddr`  out  26  IR[25:0].
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc`+4, modulo 2^32.
- `retired`  out  32  count of retired instructions.
- `fault`  out  1  misaligned PC target detected; sticky until reset.

## Operation
- States: IDLE, REQ, VALID, FAULT. All outputs are Moore, driven from registers or the state.
- Reset (while `reset`=1 at an edge):
  - state ← IDLE.
  - `pc` ← `RESET_PC`, IR ← 0, `retired` ← 0, `fault` ← 0.
  - Outputs during and immediately after reset: `imem_req`=0, `instr_valid`=0, all field outputs 0, `pc_plus4`=`RESET_PC`+4.
- IDLE: `imem_req`=0. Goes unconditionally to REQ on the next edge.
- REQ:
  - `imem_req`=1; `imem_addr`=`pc`, held stable.
  - On `imem_ack`=1: IR ← `imem_rdata`, go to VALID.
  - Otherwise stay in REQ. There is no timeout.
- VALID:
  - `instr_valid`=1; field outputs reflect IR and stay stable until retire.
  - On `instr_ready`=1:
    - if `pc_enab`=1 and `pc_next[1:0]`≠0: go to FAULT; `pc` and `retired` are unchanged.
    - else if `pc_enab`=1: `pc` ← `pc_next`, `retired`++, go to REQ.
    - else: `pc` ← `pc`+4, `retired`++, go to REQ.
  - `pc_enab` and `pc_next` are ignored in any cycle where `instr_ready`=0.
- FAULT: `imem_req`=0, `instr_valid`=0, `fault`=1. IR and `pc` are frozen. The only exit is reset.
- `imem_ack` outside REQ and `instr_ready` outside VALID are ignored.
- Arithmetic:
  - `pc`+4 and `retired`+1 wrap modulo 2^32 silently.
  - `pc_plus4` is combinational from `pc`.

## Timing
- With memory acknowledging in the same cycle and the controller ready in the same cycle, each instruction takes 2 cycles: REQ for 1, VALID for 1.
- Fetch latency: each wait cycle of memory adds 1 cycle in REQ.
- Fields and `instr_valid` appear on the edge after `imem_ack`.
- The new `pc` and the next `imem_req` appear on the edge after `instr_ready`. `retired` updates on the same edge.
- The first `imem_req` is asserted 1 cycle after reset deasserts (the IDLE cycle).
- Reset takes priority over every event in the same cycle, including a simultaneous `imem_ack` or `instr_ready`. A request in flight is abandoned, and an ack arriving later while in IDLE is ignored.

## Test plan
- Reset, then zero-wait memory returning 32'h8C08_0004 at address 0:
  - `imem_req`=1 one cycle after reset.
  - Next cycle: `instr_valid`=1, `op`=6'h23, `rt`=8, `imm`=16'h0004.
  - Assert `instr_ready` with `pc_enab`=0 → `pc`=4, `retired`=1, `imem_addr`=4.
- Memory acks 3 cycles after request:
  - `imem_req` and `imem_addr` stay stable for 4 cycles.
  - `instr_valid`=0 throughout, then rises 1 cycle after the ack.
- Hold `instr_ready`=0 for 5 cycles in VALID with `pc_enab` toggling:
  - fields and `pc` stay stable.
  - `pc_next` is not loaded.
  - `retired` is unchanged.
- Retire with `pc_enab`=1 and `pc_next`=32'h40 → next `imem_addr`=32'h40, `pc_plus4`=32'h44.
- Retire with `pc_enab`=1 and `pc_next`=32'h42:
  - `fault`=1, `imem_req`=0, `instr_valid`=0.
  - `pc` and `retired` are unchanged; the block stays in this state until reset.
- Wrap-around with `RESET_PC`=32'hFFFF_FFFC: sequential retire → `imem_addr`=0.
- Reset asserted mid-REQ with an ack arriving in the next cycle → IR stays 0, `pc`=`RESET_PC`, first new request issues 1 cycle after reset deasserts.

Source files
------------

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, fetches into IR, holds the instruction until the controller retires it.
// An instruction takes 1 cycle in REQ per memory wait plus 1, and holds in VALID while instr_ready_i is low.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        pc_enab_i,
  input  logic [31:0] pc_next_i,
  output logic [5:0]  op_o,
  output logic [5:0]  funct_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [15:0] imm_o,
  output logic [25:0] jaddr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] retired_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_FAULT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] retired_q;
  logic        req_q;
  logic        vld_q;
  logic        fault_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] retired_d;
  logic        misaligned_d;

  assign pc_plus4_d   = pc_q + 32'd4;
  assign retired_d    = retired_q + 32'd1;
  assign misaligned_d = pc_enab_i && (pc_next_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack_i) begin
            ir_q    <= imem_rdata_i;
            state_q <= S_VALID;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        S_VALID: begin
          if (instr_ready_i) begin
            vld_q <= 1'b0;
            // A misaligned target parks the stage without retiring the instruction.
            if (misaligned_d) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q      <= pc_enab_i ? pc_next_i : pc_plus4_d;
              retired_q <= retired_d;
              state_q   <= S_REQ;
              req_q     <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = vld_q;
  assign op_o          = ir_q[31:26];
  assign funct_o       = ir_q[5:0];
  assign rs_o          = ir_q[25:21];
  assign rt_o          = ir_q[20:16];
  assign rd_o          = ir_q[15:11];
  assign imm_o         = ir_q[15:0];
  assign jaddr_o       = ir_q[25:0];
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4_d;
  assign retired_o     = retired_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: a second instance with a top-of-memory reset PC shares the stimulus.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_ready_i = 1'b0;
  logic        pc_enab_i = 1'b0;
  logic [31:0] pc_next_i = '0;

  logic        imem_req_o, instr_valid_o, fault_o;
  logic [31:0] imem_addr_o, pc_o, pc_plus4_o, retired_o;
  logic [5:0]  op_o, funct_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [15:0] imm_o;
  logic [25:0] jaddr_o;

  logic        w_req, w_vld, w_fault;
  logic [31:0] w_addr, w_pc, w_plus4, w_ret;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  logic [25:0] w_jaddr;

  always #5 clk = ~clk;

  ifetch_unit u_dut (
    .clk_i(clk), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .pc_enab_i(pc_enab_i), .pc_next_i(pc_next_i),
    .op_o(op_o), .funct_o(funct_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
    .imm_o(imm_o), .jaddr_o(jaddr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .retired_o(retired_o), .fault_o(fault_o)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_w (
    .clk_i(clk), .reset_i(reset_i),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(w_vld), .instr_ready_i(instr_ready_i),
    .pc_enab_i(pc_enab_i), .pc_next_i(pc_next_i),
    .op_o(w_op), .funct_o(w_funct), .rs_o(w_rs), .rt_o(w_rt), .rd_o(w_rd),
    .imm_o(w_imm), .jaddr_o(w_jaddr), .pc_o(w_pc), .pc_plus4_o(w_plus4),
    .retired_o(w_ret), .fault_o(w_fault)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;
  logic [31:0] model_ret;
  logic [31:0] cur_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    tick();
    tick();
    model_pc  = 32'h0;
    model_ret = 32'h0;
    exp_q.delete();
  endtask

  // Expects the DUT in REQ; memory answers after wcyc wait cycles.
  task automatic fetch(input logic [31:0] instr, input int wcyc);
    exp_t e;
    for (int i = 0; i <= wcyc; i++) begin
      check("req_hold", 32'(imem_req_o), 32'd1);
      check("addr_hold", imem_addr_o, model_pc);
      check("vld_low", 32'(instr_valid_o), 32'd0);
      if (i < wcyc) tick();
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = instr;
    e.addr  = model_pc;
    e.instr = instr;
    exp_q.push_back(e);
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    check("vld_rise", 32'(instr_valid_o), 32'd1);
    check("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cur_instr = e.instr;
      check("op", 32'(op_o), 32'(e.instr[31:26]));
      check("funct", 32'(funct_o), 32'(e.instr[5:0]));
      check("rs", 32'(rs_o), 32'(e.instr[25:21]));
      check("rt", 32'(rt_o), 32'(e.instr[20:16]));
      check("rd", 32'(rd_o), 32'(e.instr[15:11]));
      check("imm", 32'(imm_o), 32'(e.instr[15:0]));
      check("jaddr", 32'(jaddr_o), 32'(e.instr[25:0]));
      check("ipc", pc_o, e.addr);
    end
  endtask

  task automatic retire(input logic enab, input logic [31:0] tgt);
    instr_ready_i = 1'b1;
    pc_enab_i     = enab;
    pc_next_i     = tgt;
    tick();
    instr_ready_i = 1'b0;
    pc_enab_i     = $urandom_range(0, 1);
    pc_next_i     = $urandom;
    if (enab && tgt[1:0] != 2'b00) begin
      check("flt_set", 32'(fault_o), 32'd1);
      check("flt_req", 32'(imem_req_o), 32'd0);
      check("flt_vld", 32'(instr_valid_o), 32'd0);
      check("flt_pc", pc_o, model_pc);
      check("flt_ret", retired_o, model_ret);
    end else begin
      model_pc  = enab ? tgt : model_pc + 32'd4;
      model_ret = model_ret + 32'd1;
      check("ret_pc", pc_o, model_pc);
      check("ret_addr", imem_addr_o, model_pc);
      check("ret_plus4", pc_plus4_o, model_pc + 32'd4);
      check("ret_cnt", retired_o, model_ret);
      check("ret_req", 32'(imem_req_o), 32'd1);
      check("ret_vld", 32'(instr_valid_o), 32'd0);
      check("ret_flt", 32'(fault_o), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    logic [31:0] hold_pc;

    apply_reset();
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_vld", 32'(instr_valid_o), 32'd0);
    check("rst_op", 32'(op_o), 32'd0);
    check("rst_jaddr", 32'(jaddr_o), 32'd0);
    check("rst_funct", 32'(funct_o), 32'd0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_plus4", pc_plus4_o, 32'h4);
    check("rst_ret", retired_o, 32'h0);
    check("rst_flt", 32'(fault_o), 32'd0);
    check("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("w_rst_plus4", w_plus4, 32'h0);

    reset_i = 1'b0;
    check("idle_req", 32'(imem_req_o), 32'd0);
    tick();
    check("first_req", 32'(imem_req_o), 32'd1);

    fetch(32'h8C08_0004, 0);
    check("lw_op", 32'(op_o), 32'h23);
    check("lw_rt", 32'(rt_o), 32'd8);
    check("lw_imm", 32'(imm_o), 32'h4);
    retire(1'b0, 32'h0);
    check("w_wrap_addr", w_addr, 32'h0);
    check("w_wrap_plus4", w_plus4, 32'h4);
    check("w_ret", w_ret, 32'd1);

    fetch(32'h0123_4567, 3);

    // Stalled in VALID with noise on every ignored input.
    hold_pc = model_pc;
    for (int i = 0; i < 5; i++) begin
      pc_enab_i    = i[0];
      pc_next_i    = 32'h100;
      imem_ack_i   = 1'b1;
      imem_rdata_i = $urandom;
      tick();
      check("hold_vld", 32'(instr_valid_o), 32'd1);
      check("hold_imm", 32'(imm_o), 32'(cur_instr[15:0]));
      check("hold_op", 32'(op_o), 32'(cur_instr[31:26]));
      check("hold_pc", pc_o, hold_pc);
      check("hold_ret", retired_o, model_ret);
      check("hold_req", 32'(imem_req_o), 32'd0);
    end
    imem_ack_i = 1'b0;

    retire(1'b1, 32'h40);
    check("br_addr", imem_addr_o, 32'h40);
    check("br_plus4", pc_plus4_o, 32'h44);

    fetch(32'h0800_0010, 1);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch(32'h0000_0020, 0);
    retire(1'b0, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);

    for (int n = 0; n < 8; n++) begin
      fetch($urandom, int'($urandom_range(0, 2)));
      tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
      retire(1'($urandom_range(0, 1)), tgt);
    end

    fetch(32'hDEAD_BEEF, 0);
    retire(1'b1, 32'h42);
    hold_pc = model_pc;
    for (int i = 0; i < 3; i++) begin
      imem_ack_i    = 1'b1;
      instr_ready_i = 1'b1;
      pc_enab_i     = 1'b0;
      imem_rdata_i  = $urandom;
      tick();
      check("fz_flt", 32'(fault_o), 32'd1);
      check("fz_req", 32'(imem_req_o), 32'd0);
      check("fz_vld", 32'(instr_valid_o), 32'd0);
      check("fz_pc", pc_o, hold_pc);
      check("fz_ret", retired_o, model_ret);
      check("fz_ir", 32'(jaddr_o), 32'(cur_instr[25:0]));
    end
    imem_ack_i    = 1'b0;
    instr_ready_i = 1'b0;

    // Reset landing on an in-flight request, with ack on and after the reset edge.
    apply_reset();
    reset_i = 1'b0;
    tick();
    check("mid_req", 32'(imem_req_o), 32'd1);
    reset_i      = 1'b1;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hFFFF_FFFF;
    tick();
    reset_i = 1'b0;
    check("mid_req_drop", 32'(imem_req_o), 32'd0);
    check("mid_ir", 32'(jaddr_o), 32'd0);
    check("mid_flt_clr", 32'(fault_o), 32'd0);
    tick();
    imem_ack_i = 1'b0;
    check("mid_ir_idle", 32'(op_o), 32'd0);
    check("mid_vld", 32'(instr_valid_o), 32'd0);
    check("mid_pc", pc_o, 32'h0);
    check("mid_new_req", 32'(imem_req_o), 32'd1);
    check("w_mid_pc", w_pc, 32'hFFFF_FFFC);
    fetch(32'h2002_0005, 0);
    retire(1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
